// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM type, lane constants and byte-enable legality for dmem_responder
package dmem_pkg;

    localparam int NB = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [NB-1:0] BE_B0 = 4'b0001;
    localparam logic [NB-1:0] BE_B1 = 4'b0010;
    localparam logic [NB-1:0] BE_B2 = 4'b0100;
    localparam logic [NB-1:0] BE_B3 = 4'b1000;
    localparam logic [NB-1:0] BE_H0 = 4'b0011;
    localparam logic [NB-1:0] BE_H1 = 4'b1100;
    localparam logic [NB-1:0] BE_W  = 4'b1111;

    // True for a naturally aligned byte/half/word whose lowest lane matches addr_lo.
    // An empty mask passes here; whether it is allowed depends on load vs store.
    function automatic logic be_legal(input logic [1:0] addr_lo, input logic [NB-1:0] be);
        case (be)
            4'b0000:             return 1'b1;
            BE_B0, BE_H0, BE_W:  return addr_lo == 2'd0;
            BE_B1:               return addr_lo == 2'd1;
            BE_B2, BE_H1:        return addr_lo == 2'd2;
            BE_B3:               return addr_lo == 2'd3;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised RAM with byte-lane-masked synchronous write and combinational read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int IDX_WIDTH  = 7,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [NB-1:0]         be,
    input  logic [IDX_WIDTH-1:0]  widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**IDX_WIDTH];

    // Update only the enabled lanes of the addressed word; contents are never reset
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem_q[widx][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time valid/ready data-memory responder with a fixed response latency.
// Define DMEM_MISALIGN_CHK_EN to reject illegal byte-enable/alignment pairs with rsp_err=1.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic                     req_we,
    input  logic [NB-1:0]            req_be,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int IDX_WIDTH = ADDRESS_WIDTH - 2;
    localparam int CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   we_q, we_d;
    logic                   bad_q, bad_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [IDX_WIDTH-1:0]   req_idx;
    logic [IDX_WIDTH-1:0]   rd_idx;
    logic [DATA_WIDTH-1:0]  ram_rdata;
    logic                   req_bad;
    logic                   ram_we;
    logic                   cur_we;
    logic                   cur_bad;

    assign req_idx   = req_addr[ADDRESS_WIDTH-1:2];
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

`ifdef DMEM_MISALIGN_CHK_EN
    assign req_bad = !be_legal(req_addr[1:0], req_be) || (req_we && req_be == '0);
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^req_addr[1:0];
    assign req_bad        = 1'b0;
`endif

    // Stores commit on the acceptance edge, so the RAM write needs no captured copy of wdata
    assign ram_we = req_valid && req_ready && req_we && !req_bad;

    // With latency 1 the RAM is read on the acceptance edge itself, before the capture exists
    assign rd_idx  = req_ready ? req_idx : idx_q;
    assign cur_we  = req_ready ? req_we : we_q;
    assign cur_bad = req_ready ? req_bad : bad_q;

    dmem_array #(
        .IDX_WIDTH (IDX_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_array (
        .CLK  (CLK),
        .we   (ram_we),
        .be   (req_be),
        .widx (req_idx),
        .wdata(req_wdata),
        .ridx (rd_idx),
        .rdata(ram_rdata)
    );

    // Next-state decode, request capture, and response capture on entry to RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_idx;
                    we_d    = req_we;
                    bad_d   = req_bad;
                    cnt_d   = CNT_LOAD;
                    state_d = (READ_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else cnt_d = cnt_q - CNT_WIDTH'(1);
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == RESP && state_q != RESP) begin
            rdata_d = (cur_we || cur_bad) ? '0 : ram_rdata;
            err_d   = cur_bad;
        end
    end

    // Control and response registers; the RAM is deliberately outside the reset domain
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder at latencies 1, 2 and 4
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [3:0] BE_TBL [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0011, 4'b1100, 4'b1111, 4'b0000};

    logic        CLK = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [8:0]  req_addr  [3];
    logic        req_we    [3];
    logic [3:0]  req_be    [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    logic [31:0] mem_m [3][128];
    int          last_acc [3];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.READ_LATENCY(g == 0 ? 1 : 2 * g)) u_dut (
            .CLK      (CLK),
            .RST      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .req_we   (req_we[g]),
            .req_be   (req_be[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    function automatic int lat(input int k);
        return k == 0 ? 1 : 2 * k;
    endfunction

    // A request is rejected when checking is on and the mask is not an aligned
    // byte/half/word starting at the addressed lane (empty mask: loads only).
    function automatic logic is_bad(input logic [1:0] lo, input logic [3:0] be, input logic we);
        int  first;
        bit  shape_ok;
        first    = 0;
        shape_ok = be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int i = 3; i >= 0; i--) if (be[i]) first = i;
        if (be == 4'b0000) return CHK && we;
        return CHK && !(shape_ok && int'(lo) == first);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full transaction on instance k, entered and left at posedge+1
    task automatic xact(input int k, input logic [8:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input int stall, input bit tput);
        int          n;
        logic        bad;
        logic [31:0] exp_rd;
        bad    = is_bad(a[1:0], b, w);
        exp_rd = (w || bad) ? 32'h0 : mem_m[k][a[8:2]];
        req_addr[k]  = a;
        req_we[k]    = w;
        req_be[k]    = b;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        rsp_ready[k] = (stall == 0);
        n = 0;
        @(negedge CLK);
        while (!req_ready[k] && n < 50) begin
            n++;
            @(negedge CLK);
        end
        check("accept_wait", n, 0);
        if (tput) check("throughput", cyc - last_acc[k], lat(k) + 1);
        last_acc[k] = cyc;
        if (w && !bad) for (int i = 0; i < 4; i++) if (b[i]) mem_m[k][a[8:2]][i*8 +: 8] = d[i*8 +: 8];
        @(posedge CLK);
        #1 req_valid[k] = 1'b0;
        n = 1;
        @(negedge CLK);
        while (!rsp_valid[k] && n < 40) begin
            n++;
            @(negedge CLK);
        end
        check("latency", n, lat(k));
        check("rdata", rsp_rdata[k], exp_rd);
        check("err", 32'(rsp_err[k]), 32'(bad));
        if (stall > 0) req_valid[k] = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge CLK);
            check("hold_valid", 32'(rsp_valid[k]), 1);
            check("hold_rdata", rsp_rdata[k], exp_rd);
            check("hold_ready", 32'(req_ready[k]), 0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge CLK);
        #1;
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b0;
        check("released", 32'(rsp_valid[k]), 0);
    endtask

    // Accept a store, then pulse reset while it is still pending
    task automatic reset_mid(input int k, input logic [8:0] a, input logic [31:0] d);
        req_addr[k]  = a;
        req_we[k]    = 1'b1;
        req_be[k]    = 4'hF;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        rsp_ready[k] = 1'b0;
        @(negedge CLK);
        check("rst_accept", 32'(req_ready[k]), 1);
        mem_m[k][a[8:2]] = d;
        @(posedge CLK);
        #1 req_valid[k] = 1'b0;
        @(negedge CLK);
        rst[k] = 1'b0;
        #1;
        check("rst_valid", 32'(rsp_valid[k]), 0);
        check("rst_ready", 32'(req_ready[k]), 1);
        @(negedge CLK);
        rst[k] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("post_rst_valid", 32'(rsp_valid[k]), 0);
            check("post_rst_ready", 32'(req_ready[k]), 1);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_block(input int k);
        for (int i = 0; i < 128; i++) xact(k, {7'(i), 2'b00}, 1'b1, 4'hF, $urandom, 0, 1'b0);
        xact(k, 9'h010, 1'b1, 4'hF, 32'hDEADBEEF, 0, 1'b0);
        xact(k, 9'h010, 1'b0, 4'hF, 32'h0, 0, 1'b0);
        xact(k, 9'h020, 1'b1, 4'hF, 32'h11223344, 0, 1'b0);
        xact(k, 9'h022, 1'b1, 4'b0100, 32'h00AA0000, 0, 1'b0);
        xact(k, 9'h020, 1'b0, 4'hF, 32'h0, 0, 1'b0);
        xact(k, 9'h040, 1'b1, 4'hF, 32'hCAFEF00D, 0, 1'b0);
        xact(k, 9'h041, 1'b1, 4'b0011, 32'h0000BEEF, 0, 1'b0);
        xact(k, 9'h040, 1'b0, 4'hF, 32'h0, 0, 1'b0);
        xact(k, 9'h010, 1'b0, 4'hF, 32'h0, 5, 1'b0);
        xact(k, 9'h020, 1'b0, 4'hF, 32'h0, 0, 1'b0);
        for (int i = 0; i < 4; i++) xact(k, 9'(i * 4), 1'b0, 4'hF, 32'h0, 0, 1'b1);
        reset_mid(k, 9'h030, $urandom);
        xact(k, 9'h030, 1'b0, 4'hF, 32'h0, 0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            logic [3:0] b;
            logic [8:0] a;
            int         f;
            b = BE_TBL[$urandom_range(0, 7)];
            a = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                f = 0;
                for (int j = 3; j >= 0; j--) if (b[j]) f = j;
                a[1:0] = 2'(f);
            end
            xact(k, a, 1'($urandom_range(0, 1)), b, $urandom, int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b0;
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            req_we[k]    = 1'b0;
            req_be[k]    = '0;
            req_wdata[k] = '0;
            rsp_ready[k] = 1'b0;
            last_acc[k]  = 0;
        end
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            check("reset_rsp_valid", 32'(rsp_valid[k]), 0);
            check("reset_rsp_rdata", rsp_rdata[k], 0);
            check("reset_rsp_err", 32'(rsp_err[k]), 0);
            check("reset_req_ready", 32'(req_ready[k]), 1);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) run_block(k);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
